// File: rtl/johnson_pkg.sv
// johnson_pkg: shared state encoding, direction codes and default sizes for johnson_step_ctrl (optional JSC_PRESCALE_EN)
package johnson_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic FWD = 1'b0;
    localparam logic REV = 1'b1;
    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 8;
    localparam int DIV_W_DEF = 4;
endpackage

// File: rtl/johnson_shift.sv
// johnson_shift: Johnson register stepping forward or backward one state per enabled edge
module johnson_shift
    import johnson_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q, count_d;
    always_comb begin
        count_d = !en ? count_q
                : dir == REV ? {count_q[WIDTH-2:0], ~count_q[WIDTH-1]}
                : {~count_q[0], count_q[WIDTH-1:1]};
    end
    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else count_q <= count_d;
    end
    assign count = count_q;
endmodule

// File: rtl/johnson_step_ctrl.sv
// johnson_step_ctrl: command-driven Johnson counter sequencer; JSC_PRESCALE_EN builds the step prescaler
module johnson_step_ctrl
    import johnson_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic             done,
    output logic             aborted
);
    state_t state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic done_q, done_d, aborted_q, aborted_d, dir_q, dir_d, step_due, step;
`ifdef JSC_PRESCALE_EN
    logic [DIV_W-1:0] tick_q, tick_d, div_q, div_d;
    assign step_due = tick_q == div_q;
    always_comb begin
        tick_d = tick_q;
        div_d = div_q;
        if (state_q == IDLE && cmd_valid) begin
            tick_d = '0;
            div_d = cmd_div;
        end else if (state_q == RUN && !abort) begin
            tick_d = step_due ? '0 : tick_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= '0;
            div_q <= '0;
        end else begin
            tick_q <= tick_d;
            div_q <= div_d;
        end
    end
`else
    logic unused_div;
    assign unused_div = ^cmd_div;
    assign step_due = 1'b1;
`endif
    // abort wins over a due step so the code freezes on the abort edge
    assign step = state_q == RUN && !abort && step_due;
    always_comb begin
        state_d = state_q;
        rem_d = rem_q;
        aborted_d = aborted_q;
        dir_d = dir_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                dir_d = cmd_dir;
                rem_d = cmd_steps;
                aborted_d = 1'b0;
                state_d = cmd_steps == '0 ? DONE : RUN;
            end
            RUN: if (abort) begin
                state_d = DONE;
                aborted_d = 1'b1;
            end else if (step_due) begin
                rem_d = rem_q - 1'b1;
                state_d = rem_q == CNT_W'(1) ? DONE : RUN;
            end
            default: state_d = IDLE;
        endcase
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q <= '0;
            done_q <= 1'b0;
            aborted_q <= 1'b0;
            dir_q <= FWD;
        end else begin
            state_q <= state_d;
            rem_q <= rem_d;
            done_q <= done_d;
            aborted_q <= aborted_d;
            dir_q <= dir_d;
        end
    end
    johnson_shift #(.WIDTH(WIDTH)) u_shift (
        .clk(clk),
        .reset(reset),
        .en(step),
        .dir(dir_q),
        .count(count)
    );
    assign cmd_ready = state_q == IDLE;
    assign busy = state_q == RUN;
    assign remaining = rem_q;
    assign done = done_q;
    assign aborted = aborted_q;
endmodule
